seq_det_frame_ctrl: RTL and testbench
=====================================

Name: seq_det_frame_ctrl

Overview:
Frame sequencer for the team's serial sequence detectors. It accepts a parallel word over a valid/ready handshake and clears the attached detector with a one-cycle pulse. It then streams the word MSB-first onto the detector's serial input and counts the detector's det_out pulses, one sample per streamed bit. The per-frame result is returned over a second valid/ready handshake. It sits between a host/testbench word source and any single-bit-in / single-bit-out detector.

Parameters:
WIDTH, 8, frame length in bits (>=2)
CNT_W, 4, width of detection counter; counter saturates at 2^CNT_W-1

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  frame word offered
in_data  input  WIDTH  frame word, bit WIDTH-1 streamed first
in_ready  output  1  controller can accept a word
ser_out  output  1  serial bit to detector serin
det_clr  output  1  active-high synchronous-use clear to detector rst
det_in  input  1  detector det_out (registered in detector)
res_valid  output  1  result available
res_count  output  CNT_W  detections in last frame
res_hit  output  1  res_count != 0
res_ready  input  1  result consumer ready
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; shift reg, bit index, count cleared. in_ready=1, ser_out=0, det_clr=0, res_valid=0, res_count=0, res_hit=0, busy=0.
- All outputs are decoded from registered state/regs; no combinational path from any input to any output.
- States: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE: in_ready=1. At an edge with in_valid=1, load in_data into sreg, clear count and idx, go to CLR. Otherwise stay.
- CLR (exactly 1 cycle): det_clr=1, ser_out=0, in_ready=0. Go to SHIFT.
- SHIFT: ser_out=sreg[WIDTH-1]. Each edge shifts sreg left (LSB fill 0) and increments idx. det_in is sampled at edges where idx>=1; sample=1 increments count. At the edge where idx=WIDTH-1, go to DRAIN.
- DRAIN (1 cycle): ser_out=0. det_in is sampled once more. This captures the detection caused by the last bit, given the detector's one-cycle output latency. Go to DONE.
- Total samples per frame: exactly WIDTH, one per bit. det_in during CLR and SHIFT idx=0 is ignored.
- DONE: res_valid=1 and res_count holds the frame count. At an edge with res_ready=1, go to IDLE and deassert res_valid the next cycle; res_count and res_hit hold their value until the next frame's CLR.
- Latency: acceptance edge E0 → CLR after E0 → SHIFT after E1..E(WIDTH) → DRAIN after E(WIDTH+1) → res_valid=1 after E(WIDTH+2). Throughput is at most one frame per WIDTH+4 cycles with res_ready held high.
- Count saturates at 2^CNT_W-1; it never wraps.
- in_valid while not in IDLE is ignored; the word is not consumed because in_ready=0.
- res_ready outside DONE has no effect.
- Reset mid-frame: abort immediately to the reset values; partial count is discarded and no result is produced.
- det_clr is asserted only in CLR. The detector is not cleared between bits, so overlap rules belong to the detector.

Test Plan:
- Reset: drive rst=0 mid-SHIFT of a frame → next cycle: state IDLE, in_ready=1, busy=0, res_valid=0, ser_out=0, count 0; after release, no stale result appears.
- Single frame: WIDTH=8, in_data=8'b1101_0110; stub det_in pulses 1 cycle after bits 2 and 7 → ser_out sequence 1,1,0,1,0,1,1,0 in cycles E1..E8; det_clr high only in the cycle after E0; res_valid high after E10; res_count=2, res_hit=1.
- No detection: in_data=8'h00, det_in held 0 → res_count=0, res_hit=0, res_valid after E10.
- Ignored samples: det_in=1 in the CLR cycle and the first SHIFT cycle only → res_count=0. Separately, det_in=1 only in DRAIN → res_count=1.
- Saturation: CNT_W=2, det_in held 1 throughout the frame → res_count=3, no wrap.
- Handshake back-pressure: hold res_ready=0 for 5 cycles in DONE while in_valid=1 with a new word → res_valid and res_count stable and in_ready=0 throughout. res_ready=1 → IDLE next cycle, new word accepted at the following edge, back-to-back frame result correct.

Source files
------------

// File: rtl/seq_det_frame_ctrl.sv
// Frame sequencer for serial sequence detectors: accepts a word, clears the detector,
// streams the word MSB-first and counts detector pulses, then returns the count.
module seq_det_frame_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             det_clr,
    input  logic             det_in,
    output logic             res_valid,
    output logic [CNT_W-1:0] res_count,
    output logic             res_hit,
    input  logic             res_ready,
    output logic             busy
);

    localparam int               IDX_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count;
    logic             sample;

    // NOTE: state-holding blocks use non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        det_clr   = 1'b0;
        ser_out   = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = S_CLR;
            end
            S_CLR: begin
                det_clr  = 1'b1;
                state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                ser_out = sreg[WIDTH-1];
                if (idx == IDX_LAST) state_nx = S_DRAIN;
            end
            S_DRAIN: state_nx = S_DONE;
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // The detector answers one cycle after each bit, so the first SHIFT cycle
    // still shows the cleared detector and the DRAIN cycle shows the last bit.
    assign sample = ((state == S_SHIFT) && (idx != '0)) || (state == S_DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg  <= '0;
            idx   <= '0;
            count <= '0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                sreg  <= in_data;
                idx   <= '0;
                count <= '0;
            end else if (state == S_SHIFT) begin
                sreg <= {sreg[WIDTH-2:0], 1'b0};
                idx  <= idx + 1'b1;
            end
            if (sample && det_in && count != CNT_MAX) count <= count + 1'b1;
        end
    end

    assign res_count = count;
    assign res_hit   = (count != '0);

endmodule

// File: tb/tb_seq_det_frame_ctrl.sv
// Bench for seq_det_frame_ctrl: a cycle-timeline reference model checked every cycle
// against two instances (wide and narrow counter), plus directed literal frames.
module tb_seq_det_frame_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int SAT_W = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         det_in = 1'b0;
    logic         res_ready = 1'b0;
    logic         chk_en = 1'b0;

    logic             a_in_ready, a_ser_out, a_det_clr, a_res_valid, a_res_hit, a_busy;
    logic [CNT_W-1:0] a_res_count;
    logic             s_in_ready, s_ser_out, s_det_clr, s_res_valid, s_res_hit, s_busy;
    logic [SAT_W-1:0] s_res_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_det_frame_ctrl #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
        .ser_out(a_ser_out), .det_clr(a_det_clr), .det_in(det_in), .res_valid(a_res_valid),
        .res_count(a_res_count), .res_hit(a_res_hit), .res_ready(res_ready), .busy(a_busy)
    );

    seq_det_frame_ctrl #(.WIDTH(W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
        .ser_out(s_ser_out), .det_clr(s_det_clr), .det_in(det_in), .res_valid(s_res_valid),
        .res_count(s_res_count), .res_hit(s_res_hit), .res_ready(res_ready), .busy(s_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_t counts cycles since the accepting edge. Cycle 1 clears,
    // cycles 2..W+1 carry word bits MSB-first, det_in is counted in cycles 3..W+2,
    // and the result is offered from cycle W+3 until res_ready is seen.
    logic         m_busy, m_done;
    int           m_t, m_raw;
    logic [W-1:0] m_word;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_t    <= 0;
            m_raw  <= 0;
            m_word <= '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_t    <= 1;
                m_word <= in_data;
                m_raw  <= 0;
            end
        end else if (m_done) begin
            if (res_ready) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end
        end else begin
            if (m_t >= 3 && det_in) m_raw <= m_raw + 1;
            m_t <= m_t + 1;
            if (m_t == W + 2) m_done <= 1'b1;
        end
    end

    logic             e_ser, e_clr, e_hit;
    logic [CNT_W-1:0] e_cnt_a;
    logic [SAT_W-1:0] e_cnt_s;

    assign e_ser   = (m_busy && !m_done && m_t >= 2 && m_t <= W + 1) ? m_word[W+1-m_t] : 1'b0;
    assign e_clr   = m_busy && !m_done && (m_t == 1);
    assign e_hit   = (m_raw != 0);
    assign e_cnt_a = (m_raw > (2**CNT_W - 1)) ? CNT_W'(2**CNT_W - 1) : CNT_W'(m_raw);
    assign e_cnt_s = (m_raw > (2**SAT_W - 1)) ? SAT_W'(2**SAT_W - 1) : SAT_W'(m_raw);

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_main",
                  {a_in_ready, a_busy, a_ser_out, a_det_clr, a_res_valid, a_res_hit, a_res_count},
                  {!m_busy, m_busy, e_ser, e_clr, m_done, e_hit, e_cnt_a});
            check("cycle_sat",
                  {s_in_ready, s_busy, s_ser_out, s_det_clr, s_res_valid, s_res_hit, s_res_count},
                  {!m_busy, m_busy, e_ser, e_clr, m_done, e_hit, e_cnt_s});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame from IDLE; pat[t] is det_in during cycle t after acceptance.
    task automatic run_frame(input string name, input logic [W-1:0] word,
                             input logic [W+2:1] pat, input int exp_cnt, input int exp_sat,
                             input int stall, input logic hold_next,
                             input logic [W-1:0] next_word);
        logic [W+2:1] rec_clr, rec_valid;
        logic [W-1:0] got_ser;
        in_valid  = 1'b1;
        in_data   = word;
        res_ready = 1'b0;
        det_in    = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int t = 1; t <= W + 2; t++) begin
            det_in = pat[t];
            @(negedge clk);
            rec_clr[t]   = a_det_clr;
            rec_valid[t] = a_res_valid;
            if (t >= 2 && t <= W + 1) got_ser[W+1-t] = a_ser_out;
            tick();
        end
        det_in = 1'b0;
        @(negedge clk);
        check({name, "_ser_seq"}, got_ser, word);
        check({name, "_clr_only_first"}, rec_clr, 1);
        check({name, "_valid_late"}, rec_valid, 0);
        check({name, "_res_valid"}, a_res_valid, 1);
        check({name, "_count"}, a_res_count, exp_cnt);
        check({name, "_count_sat"}, s_res_count, exp_sat);
        check({name, "_hit"}, a_res_hit, exp_cnt != 0);
        if (hold_next) begin
            in_valid = 1'b1;
            in_data  = next_word;
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            @(negedge clk);
            check({name, "_stall_in_ready"}, a_in_ready, 0);
            check({name, "_stall_valid"}, a_res_valid, 1);
            check({name, "_stall_count"}, a_res_count, exp_cnt);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        check({name, "_release_valid"}, a_res_valid, 0);
        check({name, "_release_in_ready"}, a_in_ready, 1);
        check({name, "_release_count_held"}, a_res_count, exp_cnt);
    endtask

    initial begin
        logic [W+2:1] p;
        repeat (2) tick();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_busy", a_busy, 0);
        check("rst_res_valid", a_res_valid, 0);
        check("rst_count", a_res_count, 0);
        tick();
        rst = 1'b1;
        tick();

        p = '0; p[4] = 1'b1; p[9] = 1'b1;
        run_frame("single", 8'b1101_0110, p, 2, 2, 0, 1'b0, '0);
        p = '0;
        run_frame("zero", 8'h00, p, 0, 0, 1, 1'b0, '0);
        p = '0; p[1] = 1'b1; p[2] = 1'b1;
        run_frame("ignored", 8'hFF, p, 0, 0, 0, 1'b0, '0);
        p = '0; p[W+2] = 1'b1;
        run_frame("drain_only", 8'h5A, p, 1, 1, 0, 1'b0, '0);
        p = '1;
        run_frame("saturate", 8'hC3, p, 8, 3, 0, 1'b0, '0);
        p = '0; p[3] = 1'b1; p[5] = 1'b1; p[7] = 1'b1;
        run_frame("backpress", 8'hA5, p, 3, 3, 5, 1'b1, 8'h3C);
        p = '0; p[W+2] = 1'b1;
        run_frame("back2back", 8'h3C, p, 1, 1, 0, 1'b0, '0);

        // Abort mid-SHIFT with detections already counted.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        in_valid = 1'b0;
        det_in   = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", a_in_ready, 1);
        check("abort_busy", a_busy, 0);
        check("abort_ser_out", a_ser_out, 0);
        check("abort_res_valid", a_res_valid, 0);
        check("abort_count", a_res_count, 0);
        tick();
        rst    = 1'b1;
        det_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_stale", a_res_valid, 0);
            tick();
        end

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) == 0);
            in_data   = W'($urandom);
            det_in    = $urandom_range(0, 1) != 0;
            res_ready = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
